ps2_key_decoder: RTL and testbench
==================================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning event FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  system clock; all state on posedge clk.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port byte_valid  input  1  one-cycle strobe: one received PS/2 byte is present on byte_in.
REQ-005 SHALL have port byte_in  input  8  received scan byte, LSB-first order already corrected.
REQ-006 SHALL have port parity_error  input  1  qualifies byte_in; high = byte corrupt.
REQ-007 SHALL have port evt_valid  output  1  FIFO not empty; head event on evt_* fields.
REQ-008 SHALL have port evt_ready  input  1  consumer pops head when evt_valid & evt_ready.
REQ-009 SHALL have port evt_code  output  8  head event base scan code.
REQ-010 SHALL have port evt_ext  output  1  head event had E0 prefix.
REQ-011 SHALL have port evt_break  output  1  head event is release (F0 prefix).
REQ-012 SHALL have port held  output  8  live key-down map {right,left,down,up,D,S,A,W} as bits [7:0].
REQ-013 SHALL have port overflow  output  1  sticky: an event was dropped because the FIFO was full.
REQ-014 SHALL have port clr_ovf  input  1  synchronous clear of overflow.
REQ-015 SHALL have port err_count  output  4  saturating count of parity-bad bytes.

Function
REQ-016 SHALL implement prefix FSM states IDLE, EXT, BRK, EXTBRK; transitions occur only on byte_valid cycles.
REQ-017 IDLE: E0 -> EXT; F0 -> BRK; other -> emit make event (ext=0), stay IDLE.
REQ-018 EXT: F0 -> EXTBRK; E0 -> stay EXT; other -> emit make (ext=1), -> IDLE.
REQ-019 BRK: other (not E0/F0) -> emit break (ext=0), -> IDLE; E0 or F0 -> discard sequence, -> IDLE.
REQ-020 EXTBRK: other (not E0/F0) -> emit break (ext=1), -> IDLE; E0 or F0 -> discard, -> IDLE.
REQ-021 A byte with parity_error=1 SHALL not be decoded; FSM -> IDLE, err_count += 1 saturating at 15.
REQ-022 Emitted event SHALL be pushed into FIFO on the cycle after byte_valid; evt_valid SHALL rise no later than 2 cycles after the final byte_valid when FIFO was empty.
REQ-023 FIFO SHALL be first-word-fall-through; evt_* SHALL hold stable while evt_valid & !evt_ready.
REQ-024 Push when full and no pop SHALL drop the new event, leave FIFO contents unchanged, set overflow.
REQ-025 Simultaneous push and pop when full SHALL succeed both; no overflow.
REQ-026 Pop when empty SHALL be ignored; evt_* fields are don't-care while evt_valid=0.
REQ-027 Read/write pointers SHALL wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-028 clr_ovf SHALL clear overflow; if coincident with a new drop, overflow SHALL remain 1.
REQ-029 held SHALL update on the same cycle as the event push, independent of FIFO fullness: make sets, break clears bit.
REQ-030 held map: W=1D, A=1C, S=1B, D=23 (ext=0); up=75, down=72, left=6B, right=74 (ext=1); ext mismatch SHALL not affect held.
REQ-031 Repeated make (typematic) SHALL each push an event; held bit stays 1.
REQ-032 byte_valid SHALL be assumed at most once per 2 cycles; no throughput requirement beyond that.

Reset
REQ-033 reset low SHALL asynchronously force FSM=IDLE, FIFO empty, evt_valid=0, held=0, overflow=0, err_count=0; evt_code/ext/break=0.
REQ-034 Reset mid-sequence (e.g. after E0 F0) SHALL discard the partial sequence; first byte after release decodes from IDLE.

Verification
REQ-035 Bytes 1D, then F0 1D, evt_ready=1 -> events {1D,ext0,brk0} then {1D,ext0,brk1}; held[0] 1 then 0.
REQ-036 Bytes E0 75, E0 F0 75 -> events {75,ext1,brk0}, {75,ext1,brk1}; held[4] pulses 1 then 0; held[0..3] unchanged.
REQ-037 evt_ready=0, DEPTH=4, send 5 make codes 15,16,17,18,19 -> FIFO holds 15..18, overflow=1; drain order 15,16,17,18; clr_ovf -> overflow=0.
REQ-038 Full FIFO, evt_ready=1 same cycle as new push of 2A -> one pop, 2A enqueued at tail, overflow stays 0.
REQ-039 F0 with parity_error=1 then 1D -> make {1D,brk0}, err_count=1; 16 bad bytes -> err_count=15.
REQ-040 Assert reset after E0 F0 -> all outputs 0; next byte 74 -> make event {74,ext0}, held unchanged.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder.
// Folds E0 (extended) and F0 (break) prefixes into single key events, queues
// them in a small first-word-fall-through FIFO, tracks a live key-down map for
// eight game keys and counts bytes that arrived with a parity error.
module ps2_key_decoder #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_in,
    input  logic       parity_error,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic [7:0] held,
    output logic       overflow,
    input  logic       clr_ovf,
    output logic [3:0] err_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXT    = 2'd1,
        ST_BRK    = 2'd2,
        ST_EXTBRK = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } event_t;

    localparam event_t EVT_NONE = 10'h000;

    // One-hot bit of the key-down map touched by an event; zero for keys
    // outside the map or whose extended flag does not match.
    function automatic logic [7:0] key_mask(input event_t ev);
        logic [7:0] m;
        m = 8'h00;
        if (!ev.ext) begin
            case (ev.code)
                8'h1D:   m = 8'b0000_0001;  // W
                8'h1C:   m = 8'b0000_0010;  // A
                8'h1B:   m = 8'b0000_0100;  // S
                8'h23:   m = 8'b0000_1000;  // D
                default: m = 8'h00;
            endcase
        end else begin
            case (ev.code)
                8'h75:   m = 8'b0001_0000;  // up
                8'h72:   m = 8'b0010_0000;  // down
                8'h6B:   m = 8'b0100_0000;  // left
                8'h74:   m = 8'b1000_0000;  // right
                default: m = 8'h00;
            endcase
        end
        return m;
    endfunction

    // Decoder state
    state_t        state_r;
    logic          pend_valid_r;
    event_t        pend_evt_r;
    logic [3:0]    err_count_r;

    // FIFO storage and bookkeeping
    event_t        mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          evt_valid_r;
    event_t        head_r;

    // Status
    logic [7:0]    held_r;
    logic          overflow_r;

    // FIFO next-state
    logic          full_s;
    logic          do_pop_s;
    logic          do_push_s;
    logic          drop_s;
    logic [PW-1:0] wr_ptr_nxt_s;
    logic [PW-1:0] rd_ptr_nxt_s;
    logic [CW-1:0] count_nxt_s;
    event_t        head_nxt_s;
    logic [7:0]    mask_s;

    // Prefix FSM: consumes bytes, stages a completed event for the next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            pend_valid_r <= 1'b0;
            pend_evt_r   <= EVT_NONE;
            err_count_r  <= 4'd0;
        end else begin
            pend_valid_r <= 1'b0;
            if (byte_valid) begin
                if (parity_error) begin
                    // A corrupt byte can't be trusted as prefix or code: restart.
                    state_r <= ST_IDLE;
                    if (err_count_r != 4'hF) begin
                        err_count_r <= err_count_r + 4'd1;
                    end
                end else begin
                    case (state_r)
                        ST_IDLE: begin
                            if (byte_in == PFX_EXT) begin
                                state_r <= ST_EXT;
                            end else if (byte_in == PFX_BRK) begin
                                state_r <= ST_BRK;
                            end else begin
                                pend_valid_r <= 1'b1;
                                pend_evt_r   <= {byte_in, 1'b0, 1'b0};
                                state_r      <= ST_IDLE;
                            end
                        end
                        ST_EXT: begin
                            if (byte_in == PFX_BRK) begin
                                state_r <= ST_EXTBRK;
                            end else if (byte_in == PFX_EXT) begin
                                state_r <= ST_EXT;
                            end else begin
                                pend_valid_r <= 1'b1;
                                pend_evt_r   <= {byte_in, 1'b1, 1'b0};
                                state_r      <= ST_IDLE;
                            end
                        end
                        ST_BRK: begin
                            // A prefix right after F0 is malformed: drop the sequence.
                            if ((byte_in == PFX_EXT) || (byte_in == PFX_BRK)) begin
                                state_r <= ST_IDLE;
                            end else begin
                                pend_valid_r <= 1'b1;
                                pend_evt_r   <= {byte_in, 1'b0, 1'b1};
                                state_r      <= ST_IDLE;
                            end
                        end
                        ST_EXTBRK: begin
                            if ((byte_in == PFX_EXT) || (byte_in == PFX_BRK)) begin
                                state_r <= ST_IDLE;
                            end else begin
                                pend_valid_r <= 1'b1;
                                pend_evt_r   <= {byte_in, 1'b1, 1'b1};
                                state_r      <= ST_IDLE;
                            end
                        end
                        default: begin
                            state_r <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    // FIFO push/pop decisions and the head entry as seen after this edge.
    always_comb begin
        full_s    = (count_r == CW'(DEPTH));
        do_pop_s  = (count_r != {CW{1'b0}}) && evt_ready;
        // A pop on the same edge frees the slot, so a full FIFO can still accept.
        do_push_s = pend_valid_r && (!full_s || do_pop_s);
        drop_s    = pend_valid_r && full_s && !do_pop_s;

        if (do_push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PW'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (do_pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PW'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        case ({do_push_s, do_pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase

        // The new head is the entry being written when it lands in the read slot
        // (FIFO empty, or down to one entry that is popped this edge).
        if (count_nxt_s == {CW{1'b0}}) begin
            head_nxt_s = EVT_NONE;
        end else if (do_push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = pend_evt_r;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end

        mask_s = key_mask(pend_evt_r);
    end

    // FIFO storage write; contents are meaningless until referenced by count.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= pend_evt_r;
        end
    end

    // FIFO pointers, occupancy and registered head outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            evt_valid_r <= 1'b0;
            head_r      <= EVT_NONE;
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            evt_valid_r <= (count_nxt_s != {CW{1'b0}});
            head_r      <= head_nxt_s;
        end
    end

    // Key-down map follows every decoded event, even one the FIFO drops;
    // overflow is sticky and a coincident drop wins over the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held_r     <= 8'h00;
            overflow_r <= 1'b0;
        end else begin
            if (pend_valid_r) begin
                if (pend_evt_r.brk) begin
                    held_r <= held_r & ~mask_s;
                end else begin
                    held_r <= held_r | mask_s;
                end
            end
            overflow_r <= drop_s | (overflow_r & ~clr_ovf);
        end
    end

    assign evt_valid = evt_valid_r;
    assign evt_code  = head_r.code;
    assign evt_ext   = head_r.ext;
    assign evt_break = head_r.brk;
    assign held      = held_r;
    assign overflow  = overflow_r;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed vector table, hand-written
// FIFO/reset corner sequences, then random traffic against a queue-based model.
module tb_ps2_key_decoder;

    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic       byte_valid;
    logic [7:0] byte_in;
    logic       parity_error;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic [7:0] held;
    logic       overflow;
    logic       clr_ovf;
    logic [3:0] err_count;

    ps2_key_decoder #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .byte_valid   (byte_valid),
        .byte_in      (byte_in),
        .parity_error (parity_error),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_code     (evt_code),
        .evt_ext      (evt_ext),
        .evt_break    (evt_break),
        .held         (held),
        .overflow     (overflow),
        .clr_ovf      (clr_ovf),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [7:0] b;
        logic       perr;
        logic       ev;
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [7:0] held;
        logic [3:0] err;
    } vec_t;

    vec_t tbl[$];

    task automatic addv(input logic [7:0] b, input logic perr, input logic ev,
                        input logic [7:0] code, input logic ext, input logic brk,
                        input logic [7:0] hm, input logic [3:0] err);
        vec_t v;
        v.b = b; v.perr = perr; v.ev = ev; v.code = code;
        v.ext = ext; v.brk = brk; v.held = hm; v.err = err;
        tbl.push_back(v);
    endtask

    // Strobe one byte at a negedge; returns two negedges later, after the push edge.
    task automatic send_byte(input logic [7:0] b, input logic perr);
        byte_in      = b;
        parity_error = perr;
        byte_valid   = 1'b1;
        @(negedge clk);
        byte_valid   = 1'b0;
        parity_error = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop_expect(input string name, input logic [7:0] code, input logic ext, input logic brk);
        check(name, {21'h0, evt_valid, evt_code, evt_ext, evt_break}, {21'h0, 1'b1, code, ext, brk});
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ev_t;

    ev_t        mq[$];
    logic [7:0] pfx[$];
    logic       m_pend;
    ev_t        m_pend_ev;
    logic [7:0] m_held;
    logic       m_ovf;
    int         m_err;

    function automatic logic pfx_has(input logic [7:0] v);
        logic f;
        f = 1'b0;
        foreach (pfx[i]) if (pfx[i] == v) f = 1'b1;
        return f;
    endfunction

    // Key-down map bit for an event: position in this list is the bit index.
    function automatic logic [7:0] key_bit(input logic [7:0] code, input logic ext);
        logic [8:0] keys [8];
        logic [7:0] m;
        keys = '{9'h01D, 9'h01C, 9'h01B, 9'h023, 9'h175, 9'h172, 9'h16B, 9'h174};
        m = 8'h00;
        for (int i = 0; i < 8; i++) if (keys[i] == {ext, code}) m[i] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        mq.delete();
        pfx.delete();
        m_pend = 1'b0;
        m_pend_ev = 10'h000;
        m_held = 8'h00;
        m_ovf = 1'b0;
        m_err = 0;
    endtask

    // Bytes accumulate as a prefix list until a key code completes the sequence.
    task automatic model_decode(input logic [7:0] b);
        if (b == 8'hE0 || b == 8'hF0) begin
            if (pfx_has(8'hF0)) pfx.delete();
            else if (!(b == 8'hE0 && pfx_has(8'hE0))) pfx.push_back(b);
        end else begin
            m_pend    = 1'b1;
            m_pend_ev = {b, pfx_has(8'hE0), pfx_has(8'hF0)};
            pfx.delete();
        end
    endtask

    // Effect of one clock edge given the inputs presented for it.
    task automatic model_step(input logic bv, input logic [7:0] b, input logic pe,
                              input logic rdy, input logic clr);
        logic pop, full, drop;
        logic [7:0] m;
        pop  = (mq.size() != 0) && rdy;
        full = (mq.size() == DEPTH);
        drop = 1'b0;
        if (pop) void'(mq.pop_front());
        if (m_pend) begin
            if (full && !pop) drop = 1'b1;
            else mq.push_back(m_pend_ev);
            m = key_bit(m_pend_ev.code, m_pend_ev.ext);
            if (m_pend_ev.brk) m_held = m_held & ~m;
            else m_held = m_held | m;
        end
        m_ovf  = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_pend = 1'b0;
        if (bv) begin
            if (pe) begin
                pfx.delete();
                if (m_err < 15) m_err++;
            end else begin
                model_decode(b);
            end
        end
    endtask

    task automatic model_compare(input int cyc);
        logic [31:0] act, exp;
        logic ev;
        ev  = (mq.size() != 0);
        act = {8'h0, evt_valid, (evt_valid ? {evt_code, evt_ext, evt_break} : 10'h000),
               held, overflow, err_count};
        exp = {8'h0, ev, (ev ? {mq[0].code, mq[0].ext, mq[0].brk} : 10'h000),
               m_held, m_ovf, 4'(m_err)};
        check($sformatf("rand_c%0d", cyc), act, exp);
    endtask

    function automatic logic [7:0] pick_byte();
        logic [7:0] r;
        case ($urandom_range(0, 13))
            0, 1:    r = 8'hE0;
            2, 3:    r = 8'hF0;
            4:       r = 8'h1D;
            5:       r = 8'h1C;
            6:       r = 8'h1B;
            7:       r = 8'h23;
            8:       r = 8'h75;
            9:       r = 8'h72;
            10:      r = 8'h6B;
            11:      r = 8'h74;
            default: r = 8'($urandom_range(0, 255));
        endcase
        return r;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] act;
        logic [31:0] exp;
        logic        last_bv;

        reset = 1'b1;
        byte_valid = 1'b0; byte_in = 8'h00; parity_error = 1'b0;
        evt_ready = 1'b0; clr_ovf = 1'b0;
        #1 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_state", {8'h0, evt_valid, evt_code, evt_ext, evt_break, held, overflow, err_count}, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        //      byte   perr  ev    code   ext   brk   held   err
        addv(8'h1D, 1'b0, 1'b1, 8'h1D, 1'b0, 1'b0, 8'h01, 4'd0);
        addv(8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 4'd0);
        addv(8'h1D, 1'b0, 1'b1, 8'h1D, 1'b0, 1'b1, 8'h00, 4'd0);
        addv(8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'd0);
        addv(8'h75, 1'b0, 1'b1, 8'h75, 1'b1, 1'b0, 8'h10, 4'd0);
        addv(8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h10, 4'd0);
        addv(8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h10, 4'd0);
        addv(8'h75, 1'b0, 1'b1, 8'h75, 1'b1, 1'b1, 8'h00, 4'd0);
        addv(8'hF0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'd1);
        addv(8'h1D, 1'b0, 1'b1, 8'h1D, 1'b0, 1'b0, 8'h01, 4'd1);
        addv(8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 4'd1);
        addv(8'h1D, 1'b0, 1'b1, 8'h1D, 1'b1, 1'b0, 8'h01, 4'd1);
        addv(8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 8'h03, 4'd1);
        addv(8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 8'h03, 4'd1);
        addv(8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 4'd1);
        addv(8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 4'd1);
        addv(8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 8'h03, 4'd1);
        addv(8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 4'd1);
        addv(8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 4'd1);
        addv(8'h72, 1'b0, 1'b1, 8'h72, 1'b1, 1'b0, 8'h23, 4'd1);
        addv(8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h23, 4'd1);
        addv(8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h23, 4'd1);
        addv(8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h23, 4'd1);
        addv(8'h1B, 1'b0, 1'b1, 8'h1B, 1'b0, 1'b0, 8'h27, 4'd1);
        addv(8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h27, 4'd1);
        addv(8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h27, 4'd1);
        addv(8'h72, 1'b0, 1'b1, 8'h72, 1'b1, 1'b1, 8'h07, 4'd1);
        addv(8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h07, 4'd1);
        addv(8'h23, 1'b0, 1'b1, 8'h23, 1'b0, 1'b1, 8'h07, 4'd1);

        evt_ready = 1'b1;
        foreach (tbl[i]) begin
            send_byte(tbl[i].b, tbl[i].perr);
            act = {9'h0, evt_valid, (evt_valid ? {evt_code, evt_ext, evt_break} : 10'h000), held, err_count};
            exp = {9'h0, tbl[i].ev, (tbl[i].ev ? {tbl[i].code, tbl[i].ext, tbl[i].brk} : 10'h000),
                   tbl[i].held, tbl[i].err};
            check($sformatf("vec%0d", i), act, exp);
        end
        @(negedge clk);
        evt_ready = 1'b0;

        // Five makes into a four-deep FIFO with no consumer.
        send_byte(8'h15, 1'b0);
        send_byte(8'h16, 1'b0);
        send_byte(8'h17, 1'b0);
        send_byte(8'h18, 1'b0);
        check("full_no_ovf", {31'h0, overflow}, 32'h0);
        send_byte(8'h19, 1'b0);
        check("ovf_set", {31'h0, overflow}, 32'h1);
        pop_expect("drain0", 8'h15, 1'b0, 1'b0);
        pop_expect("drain1", 8'h16, 1'b0, 1'b0);
        pop_expect("drain2", 8'h17, 1'b0, 1'b0);
        pop_expect("drain3", 8'h18, 1'b0, 1'b0);
        check("drained_empty", {30'h0, evt_valid, overflow}, 32'h1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf_cleared", {31'h0, overflow}, 32'h0);

        // Full FIFO, push and pop on the same edge.
        send_byte(8'h15, 1'b0);
        send_byte(8'h16, 1'b0);
        send_byte(8'h17, 1'b0);
        send_byte(8'h18, 1'b0);
        byte_in = 8'h2A; byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0; evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        check("pushpop_no_ovf", {31'h0, overflow}, 32'h0);
        pop_expect("pp_drain0", 8'h16, 1'b0, 1'b0);
        pop_expect("pp_drain1", 8'h17, 1'b0, 1'b0);
        pop_expect("pp_drain2", 8'h18, 1'b0, 1'b0);
        pop_expect("pp_drain3", 8'h2A, 1'b0, 1'b0);
        check("pp_empty", {31'h0, evt_valid}, 32'h0);

        // A drop coinciding with clr_ovf keeps overflow set.
        send_byte(8'h40, 1'b0);
        send_byte(8'h41, 1'b0);
        send_byte(8'h42, 1'b0);
        send_byte(8'h43, 1'b0);
        byte_in = 8'h31; byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0; clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("clr_vs_drop", {31'h0, overflow}, 32'h1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("clr_after_drop", {31'h0, overflow}, 32'h0);
        pop_expect("cd_drain0", 8'h40, 1'b0, 1'b0);
        pop_expect("cd_drain1", 8'h41, 1'b0, 1'b0);
        pop_expect("cd_drain2", 8'h42, 1'b0, 1'b0);
        pop_expect("cd_drain3", 8'h43, 1'b0, 1'b0);

        // Parity errors saturate the counter and produce no events.
        for (int i = 0; i < 16; i++) send_byte(8'h1D, 1'b1);
        check("err_saturate", {27'h0, evt_valid, err_count}, 32'h0000000F);

        // Reset in the middle of an E0 F0 sequence.
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        reset = 1'b0;
        #1;
        check("midseq_reset", {8'h0, evt_valid, evt_code, evt_ext, evt_break, held, overflow, err_count}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send_byte(8'h74, 1'b0);
        check("after_reset_held", {24'h0, held}, 32'h0);
        pop_expect("after_reset_evt", 8'h74, 1'b0, 1'b0);

        // Random traffic against the model.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        last_bv = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic       bv, pe, rd, cl;
            logic [7:0] b;
            int         rp;
            rp = (((cyc / 250) % 2) == 0) ? 10 : 80;
            bv = !last_bv && ($urandom_range(0, 99) < 45);
            b  = pick_byte();
            pe = ($urandom_range(0, 15) == 0);
            rd = ($urandom_range(0, 99) < rp);
            cl = ($urandom_range(0, 19) == 0);
            byte_valid = bv; byte_in = b; parity_error = pe; evt_ready = rd; clr_ovf = cl;
            model_step(bv, b, pe, rd, cl);
            last_bv = bv;
            @(negedge clk);
            model_compare(cyc);
        end
        byte_valid = 1'b0; evt_ready = 1'b0; clr_ovf = 1'b0; parity_error = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
